// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle MIPS divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;
endpackage

// File: rtl/div_unit_if.sv
// CPU <-> divider bundle: operands and start from the CPU, results and status back.
// Handshake: start is sampled only while the divider is idle or done; busy marks
// the cycles in which start is ignored, done is a one-cycle result-valid pulse.
interface div_unit_if #(parameter int WIDTH = div_pkg::DIV_WIDTH);
    import div_pkg::*;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    div_state_e       state_dbg;

    modport master (
        output start, is_signed, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, state_dbg
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, state_dbg
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor always holds, so the shifted value fits in WIDTH+1 bits
    // and a kept (non-negative) difference fits back into WIDTH bits.
    always_comb begin
        shifted = {rem_in, dvd_msb};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitude restoring division, then sign fix-up into HI/LO.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic     DIV_clk,
    input  logic     DIV_rst_n,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] raw_dvd_q, raw_dvd_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_msb (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        raw_dvd_d     = raw_dvd_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dbz_d         = dbz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (bus.start) begin
                    state_d   = CALC;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    rem_d     = '0;
                    raw_dvd_d = bus.dividend;
                    dbz_d     = (bus.divisor == '0);
                    neg_quo_d = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    neg_rem_d = bus.is_signed & bus.dividend[WIDTH-1];
                    // Magnitudes stay in WIDTH bits: |most-negative| wraps to itself,
                    // which read as unsigned is the correct magnitude.
                    dvd_d = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
                    dvs_d = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d       = DONE;
                busy_d        = 1'b0;
                done_d        = 1'b1;
                div_by_zero_d = dbz_q;
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = raw_dvd_q;
                end else begin
                    quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
                    remainder_d = neg_rem_q ? -rem_q : rem_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge DIV_clk or negedge DIV_rst_n) begin
        if (!DIV_rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            raw_dvd_q     <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            dvd_q         <= dvd_d;
            dvs_q         <= dvs_d;
            raw_dvd_q     <= raw_dvd_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dbz_q         <= dbz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic vectors, latency, reset and handshake cases.
module tb_div_unit;
    import div_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    div_unit_if bus ();

    div_unit dut (
        .DIV_clk   (clk),
        .DIV_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation and waits (bounded) for done; outputs sampled on negedges.
    // lat counts negedges from the one after the accepting edge until done is seen.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor  = 32'h0000_0003;
        lat = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.quotient !== 32'd0) begin n_err++; $display("FAIL reset_q: got %h want 0", bus.quotient); end
        n_cmp++; if (bus.remainder !== 32'd0) begin n_err++; $display("FAIL reset_r: got %h want 0", bus.remainder); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
        n_cmp++; if (bus.state_dbg !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, IDLE); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int lat, bc;
        run_op(1'b0, 32'd100, 32'd7, lat, bc);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL udiv_latency: got %0d want 33", lat); end
        n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL udiv_busy_cycles: got %0d want 33", bc); end
        n_cmp++; if (bus.quotient !== 32'd14) begin n_err++; $display("FAIL udiv_q: got %h want %h", bus.quotient, 32'd14); end
        n_cmp++; if (bus.remainder !== 32'd2) begin n_err++; $display("FAIL udiv_r: got %h want %h", bus.remainder, 32'd2); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL udiv_busy_at_done: got %b want 0", bus.busy); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL udiv_done_pulse: got %b want 0", bus.done); end
        n_cmp++; if (bus.quotient !== 32'd14) begin n_err++; $display("FAIL udiv_q_hold: got %h want %h", bus.quotient, 32'd14); end
        n_cmp++; if (bus.state_dbg !== IDLE) begin n_err++; $display("FAIL udiv_state_idle: got %0d want %0d", bus.state_dbg, IDLE); end
    endtask

    // Table: signed sign rules, overflow, unsigned max, divide by zero in both modes.
    task automatic test_vectors();
        logic        sg [6];
        logic [31:0] a  [6];
        logic [31:0] b  [6];
        logic [31:0] eq [6];
        logic [31:0] er [6];
        logic        ez [6];
        int lat, bc;
        sg[0] = 1; a[0] = 32'hFFFF_FFF9; b[0] = 32'd2;        eq[0] = 32'hFFFF_FFFD; er[0] = 32'hFFFF_FFFF; ez[0] = 0;
        sg[1] = 1; a[1] = 32'd7;         b[1] = 32'hFFFF_FFFE; eq[1] = 32'hFFFF_FFFD; er[1] = 32'd1;         ez[1] = 0;
        sg[2] = 1; a[2] = 32'h8000_0000; b[2] = 32'hFFFF_FFFF; eq[2] = 32'h8000_0000; er[2] = 32'd0;         ez[2] = 0;
        sg[3] = 0; a[3] = 32'hFFFF_FFFF; b[3] = 32'd1;        eq[3] = 32'hFFFF_FFFF; er[3] = 32'd0;         ez[3] = 0;
        sg[4] = 0; a[4] = 32'd5;         b[4] = 32'd0;        eq[4] = 32'hFFFF_FFFF; er[4] = 32'd5;         ez[4] = 1;
        sg[5] = 1; a[5] = 32'd5;         b[5] = 32'd0;        eq[5] = 32'hFFFF_FFFF; er[5] = 32'd5;         ez[5] = 1;
        for (int i = 0; i < 6; i++) begin
            run_op(sg[i], a[i], b[i], lat, bc);
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL vec%0d_latency: got %0d want 33", i, lat); end
            n_cmp++; if (bus.quotient !== eq[i]) begin n_err++; $display("FAIL vec%0d_q: got %h want %h", i, bus.quotient, eq[i]); end
            n_cmp++; if (bus.remainder !== er[i]) begin n_err++; $display("FAIL vec%0d_r: got %h want %h", i, bus.remainder, er[i]); end
            n_cmp++; if (bus.div_by_zero !== ez[i]) begin n_err++; $display("FAIL vec%0d_dbz: got %b want %b", i, bus.div_by_zero, ez[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (bus.state_dbg !== CALC) begin n_err++; $display("FAIL rstmid_in_calc: got %0d want %0d", bus.state_dbg, CALC); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.quotient !== 32'd0) begin n_err++; $display("FAIL rstmid_q: got %h want 0", bus.quotient); end
        n_cmp++; if (bus.remainder !== 32'd0) begin n_err++; $display("FAIL rstmid_r: got %h want 0", bus.remainder); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL rstmid_dbz: got %b want 0", bus.div_by_zero); end
        n_cmp++; if (bus.state_dbg !== IDLE) begin n_err++; $display("FAIL rstmid_state: got %0d want %0d", bus.state_dbg, IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 32'd9, 32'd3, lat, bc);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL rstmid_latency: got %0d want 33", lat); end
        n_cmp++; if (bus.quotient !== 32'd3) begin n_err++; $display("FAIL rstmid_after_q: got %h want 3", bus.quotient); end
        n_cmp++; if (bus.remainder !== 32'd0) begin n_err++; $display("FAIL rstmid_after_r: got %h want 0", bus.remainder); end
    endtask

    task automatic test_busy_ignore();
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd10;
        @(negedge clk);
        n = 0;
        while (!bus.done && n < 100) begin
            if (n == 5) begin
                bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'd7; bus.divisor = 32'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        n_cmp++; if (n !== 33) begin n_err++; $display("FAIL ignore_latency: got %0d want 33", n); end
        n_cmp++; if (bus.quotient !== 32'd100) begin n_err++; $display("FAIL ignore_q: got %h want %h", bus.quotient, 32'd100); end
        n_cmp++; if (bus.remainder !== 32'd0) begin n_err++; $display("FAIL ignore_r: got %h want 0", bus.remainder); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd20; bus.divisor = 32'd6;
        @(negedge clk);
        // start stays high; these operands are only taken in the DONE cycle
        bus.dividend = 32'd45; bus.divisor = 32'd4;
        n = 0;
        while (!bus.done && n < 100) begin @(negedge clk); n++; end
        n_cmp++; if (n !== 33) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 33", n); end
        n_cmp++; if (bus.quotient !== 32'd3) begin n_err++; $display("FAIL b2b_first_q: got %h want 3", bus.quotient); end
        n_cmp++; if (bus.remainder !== 32'd2) begin n_err++; $display("FAIL b2b_first_r: got %h want 2", bus.remainder); end
        n = 0;
        @(negedge clk);
        n++;
        bus.start = 1'b0;
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL b2b_done_falls: got %b want 0", bus.done); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_rises: got %b want 1", bus.busy); end
        while (!bus.done && n < 100) begin @(negedge clk); n++; end
        n_cmp++; if (n !== 34) begin n_err++; $display("FAIL b2b_done_gap: got %0d want 34", n); end
        n_cmp++; if (bus.quotient !== 32'd11) begin n_err++; $display("FAIL b2b_second_q: got %h want %h", bus.quotient, 32'd11); end
        n_cmp++; if (bus.remainder !== 32'd1) begin n_err++; $display("FAIL b2b_second_r: got %h want 1", bus.remainder); end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_unsigned();
        test_vectors();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
